// File: rtl/i2s_sample_fifo.sv
// -----------------------------------------------------------------------------
// i2s_sample_fifo
//   Stereo sample buffer upstream of the I2S shift register. Absorbs bursty
//   sample writes, primes to a fill threshold, pulses start to launch the
//   serialiser, then hands out one left/right pair per rd_req. An rd_req on an
//   empty buffer while streaming is an underrun: it is pulsed, counted
//   (saturating) and answered with silence or a repeat of the last pair.
//
// Build option:
//   UNDERRUN_REPEAT_EN  defined   : underrun repeats the last popped pair
//                                   (0 if nothing popped since reset/flush)
//                       undefined : underrun outputs silence (all zeros)
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-low reset
//   flush         synchronous clear of contents and state (wins over wr/rd)
//   wr_valid      write pair offered; accepted when wr_ready is high
//   wr_ready      level < DEPTH (from current level only)
//   wr_left/right incoming sample pair
//   rd_req        one-cycle pop request from the serialiser
//   sample_left/right  registered pair to the serialiser
//   sample_valid  one-cycle pulse: new pair on sample_*
//   start         one-cycle pulse on entry to STREAMING
//   level         stored pairs, 0..DEPTH
//   almost_full   level >= AFULL_LVL
//   underrun      one-cycle pulse: rd_req while streaming with level == 0
//   underrun_cnt  saturating underrun count
// -----------------------------------------------------------------------------
module i2s_sample_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int PRIME_LVL  = 8,
  parameter int AFULL_LVL  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_left,
  input  logic [DATA_W-1:0]     wr_right,
  input  logic                  rd_req,
  output logic [DATA_W-1:0]     sample_left,
  output logic [DATA_W-1:0]     sample_right,
  output logic                  sample_valid,
  output logic                  start,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   LVL_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_PRIME = (DEPTH_LOG2+1)'(PRIME_LVL);
  localparam logic [DEPTH_LOG2:0]   LVL_AFULL = (DEPTH_LOG2+1)'(AFULL_LVL);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRIMING   = 2'd1,
    STREAMING = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_W-1:0]     mem_left  [DEPTH];
  logic [DATA_W-1:0]     mem_right [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_next;

  logic wr_fire;
  logic rd_take;
  logic pop_fire;
  logic underrun_fire;

  // Acceptance depends on the current level only: a full FIFO rejects a
  // write even when the same cycle pops a pair.
  assign wr_ready    = (level < LVL_DEPTH);
  assign almost_full = (level >= LVL_AFULL);

  // flush overrides both sides, so nothing is stored or popped that cycle.
  assign wr_fire       = wr_valid & wr_ready & ~flush;
  assign rd_take       = rd_req & (state == STREAMING) & ~flush;
  assign pop_fire      = rd_take & (level != '0);
  assign underrun_fire = rd_take & (level == '0);

  // An underrun pops nothing, so a write alongside it still grows the level.
  always_comb begin
    // NOTE: default assignment first so every path drives level_next and no
    // latch is inferred.
    level_next = level;
    if (wr_fire && !pop_fire) level_next = level + LVL_ONE;
    else if (!wr_fire && pop_fire) level_next = level - LVL_ONE;
  end

  // Sample storage. NOTE: the array is deliberately not reset; only pointers
  // and level define what is valid, and a resettable array would not map to RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_left[wr_ptr]  <= wr_left;
      mem_right[wr_ptr] <= wr_right;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments throughout, so every register samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      start        <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (flush) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      start        <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      sample_valid <= 1'b0;
      start        <= 1'b0;
      underrun     <= 1'b0;
      level        <= level_next;

      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;

      if (pop_fire) begin
        rd_ptr       <= rd_ptr + PTR_ONE;
        sample_left  <= mem_left[rd_ptr];
        sample_right <= mem_right[rd_ptr];
        sample_valid <= 1'b1;
      end

      if (underrun_fire) begin
        sample_valid <= 1'b1;
        underrun     <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
`ifdef UNDERRUN_REPEAT_EN
        // sample_* simply keep the last popped pair (zero after reset/flush).
`else
        sample_left  <= '0;
        sample_right <= '0;
`endif
      end

      // The threshold test uses the post-update level so start rises in the
      // same cycle that level first reads PRIME_LVL.
      unique case (state)
        IDLE: begin
          if (wr_fire) begin
            if (level_next >= LVL_PRIME) begin
              state <= STREAMING;
              start <= 1'b1;
            end else begin
              state <= PRIMING;
            end
          end
        end
        PRIMING: begin
          if (level_next >= LVL_PRIME) begin
            state <= STREAMING;
            start <= 1'b1;
          end
        end
        STREAMING: state <= STREAMING;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_i2s_sample_fifo
//   Self-checking bench for i2s_sample_fifo (default parameters). A queue-based
//   reference model tracks contents, stream state and outputs; a table of
//   hand-computed vectors covers priming, ordered streaming, underrun and
//   flush; short directed sequences cover full/almost_full, flush with
//   re-priming and asynchronous reset; randomized traffic finishes the run.
//   Define UNDERRUN_REPEAT_EN for both RTL and bench to check the repeat build.
// -----------------------------------------------------------------------------
module tb_i2s_sample_fifo;

  localparam int DW = 32;

`ifdef UNDERRUN_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_left;
  logic [DW-1:0] wr_right;
  logic          rd_req;
  logic [DW-1:0] sample_left;
  logic [DW-1:0] sample_right;
  logic          sample_valid;
  logic          start;
  logic [4:0]    level;
  logic          almost_full;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  i2s_sample_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_left      (wr_left),
    .wr_right     (wr_right),
    .rd_req       (rd_req),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .start        (start),
    .level        (level),
    .almost_full  (almost_full),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stream state: 0 idle, 1 priming, 2 streaming.
  logic [DW-1:0] ql[$];
  logic [DW-1:0] qr[$];
  int            m_state;
  logic [DW-1:0] m_sl, m_sr;
  logic          m_sv, m_start, m_ur;
  logic [15:0]   m_cnt;

  task automatic model_reset();
    ql.delete();
    qr.delete();
    m_state = 0;
    m_sl = '0; m_sr = '0;
    m_sv = 1'b0; m_start = 1'b0; m_ur = 1'b0;
    m_cnt = '0;
  endtask

  task automatic model_step(input logic f, input logic w, input logic r,
                            input logic [DW-1:0] l, input logic [DW-1:0] rr);
    bit wr_ok;
    if (f) begin
      model_reset();
      return;
    end
    m_sv = 1'b0; m_start = 1'b0; m_ur = 1'b0;
    wr_ok = w && (ql.size() < 16);
    if (r && m_state == 2) begin
      m_sv = 1'b1;
      if (ql.size() == 0) begin
        m_ur = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (!REPEAT) begin
          m_sl = '0;
          m_sr = '0;
        end
      end else begin
        m_sl = ql.pop_front();
        m_sr = qr.pop_front();
      end
    end
    if (wr_ok) begin
      ql.push_back(l);
      qr.push_back(rr);
    end
    if (m_state == 0 && wr_ok) m_state = 1;
    if (m_state == 1 && ql.size() >= 8) begin
      m_state = 2;
      m_start = 1'b1;
    end
  endtask

  task automatic compare_model();
    check("level",        32'(level),        32'(ql.size()));
    check("wr_ready",     32'(wr_ready),     32'(ql.size() < 16));
    check("almost_full",  32'(almost_full),  32'(ql.size() >= 12));
    check("sample_valid", 32'(sample_valid), 32'(m_sv));
    check("sample_left",  sample_left,       m_sl);
    check("sample_right", sample_right,      m_sr);
    check("start",        32'(start),        32'(m_start));
    check("underrun",     32'(underrun),     32'(m_ur));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
  endtask

  // Apply inputs, advance one edge, compare #1 after it.
  task automatic cycle(input logic f, input logic w, input logic r,
                       input logic [DW-1:0] l, input logic [DW-1:0] rr);
    flush = f; wr_valid = w; rd_req = r; wr_left = l; wr_right = rr;
    model_step(f, w, r, l, rr);
    @(posedge clk);
    #1;
    compare_model();
    flush = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          f, w, r;
    logic [DW-1:0] l, rr;
    logic [4:0]    lvl;
    logic          st, sv, ur;
    logic [DW-1:0] sl, sr;
    logic [15:0]   cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic fill_table();
    logic [DW-1:0] ur_l, ur_r;
    ur_l = REPEAT ? 32'd7   : 32'd0;
    ur_r = REPEAT ? 32'd107 : 32'd0;
    for (int i = 0; i < 8; i++)
      vecs[i] = '{f:0, w:1, r:0, l:i, rr:100+i, lvl:5'(i+1), st:(i == 7),
                  sv:0, ur:0, sl:0, sr:0, cnt:0};
    for (int i = 8; i < 16; i++)
      vecs[i] = '{f:0, w:0, r:1, l:0, rr:0, lvl:5'(15-i), st:0,
                  sv:1, ur:0, sl:i-8, sr:100+i-8, cnt:0};
    vecs[16] = '{f:0, w:0, r:1, l:0,  rr:0,   lvl:0, st:0, sv:1, ur:1, sl:ur_l, sr:ur_r, cnt:1};
    vecs[17] = '{f:0, w:1, r:1, l:19, rr:119, lvl:1, st:0, sv:1, ur:1, sl:ur_l, sr:ur_r, cnt:2};
    vecs[18] = '{f:0, w:1, r:1, l:20, rr:120, lvl:1, st:0, sv:1, ur:0, sl:19,   sr:119,  cnt:2};
    vecs[19] = '{f:1, w:1, r:1, l:21, rr:121, lvl:0, st:0, sv:0, ur:0, sl:0,    sr:0,    cnt:0};
  endtask

  int wp[4] = '{90, 50, 20, 70};
  int rp[4] = '{20, 50, 90, 70};

  initial begin
    int starts;
    rst = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    wr_left = '0; wr_right = '0;
    model_reset();
    fill_table();

    // Reset state.
    #2;
    check("rst.level",        32'(level),        32'd0);
    check("rst.wr_ready",     32'(wr_ready),     32'd1);
    check("rst.sample_valid", 32'(sample_valid), 32'd0);
    check("rst.start",        32'(start),        32'd0);
    check("rst.underrun",     32'(underrun),     32'd0);
    check("rst.underrun_cnt", 32'(underrun_cnt), 32'd0);
    check("rst.sample_left",  sample_left,       32'd0);
    check("rst.almost_full",  32'(almost_full),  32'd0);
    #10;
    rst = 1'b1;

    // Table: prime, ordered stream, underrun, write+read at empty/non-empty, flush.
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].f, vecs[i].w, vecs[i].r, vecs[i].l, vecs[i].rr);
      check($sformatf("tbl[%0d].level", i),        32'(level),        32'(vecs[i].lvl));
      check($sformatf("tbl[%0d].start", i),        32'(start),        32'(vecs[i].st));
      check($sformatf("tbl[%0d].sample_valid", i), 32'(sample_valid), 32'(vecs[i].sv));
      check($sformatf("tbl[%0d].underrun", i),     32'(underrun),     32'(vecs[i].ur));
      check($sformatf("tbl[%0d].sample_left", i),  sample_left,       vecs[i].sl);
      check($sformatf("tbl[%0d].sample_right", i), sample_right,      vecs[i].sr);
      check($sformatf("tbl[%0d].underrun_cnt", i), 32'(underrun_cnt), 32'(vecs[i].cnt));
    end

    // Fill to full with 17 back-to-back writes; the 17th is rejected.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'(200 + i), 32'(300 + i));
      if (i == 10) check("fill.af_at_11", 32'(almost_full), 32'd0);
      if (i == 11) check("fill.af_at_12", 32'(almost_full), 32'd1);
    end
    check("fill.level",    32'(level),    32'd16);
    check("fill.wr_ready", 32'(wr_ready), 32'd0);
    // Full with a read: write still rejected, oldest (200) popped.
    cycle(1'b0, 1'b1, 1'b1, 32'd999, 32'd999);
    check("full_rw.level", 32'(level),  32'd15);
    check("full_rw.left",  sample_left, 32'd200);
    cycle(1'b1, 1'b0, 1'b0, '0, '0);

    // Flush with write+read at level 5 while streaming.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 32'(i + 1), 32'(i + 101));
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, '0, '0);
    cycle(1'b0, 1'b0, 1'b1, '0, '0);
    check("pre_flush.underrun_cnt", 32'(underrun_cnt), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'(i + 50), 32'(i + 150));
    check("pre_flush.level", 32'(level), 32'd5);
    cycle(1'b1, 1'b1, 1'b1, 32'd77, 32'd177);
    check("flush.level",        32'(level),        32'd0);
    check("flush.sample_valid", 32'(sample_valid), 32'd0);
    check("flush.underrun_cnt", 32'(underrun_cnt), 32'd0);
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'(i + 11), 32'(i + 111));
      starts += int'(start);
    end
    check("reprime.start_count", 32'(starts), 32'd1);
    check("reprime.start_last",  32'(start),  32'd1);

    // Asynchronous reset between clock edges, mid-stream.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, '0, '0);
    check("pre_rst.left", sample_left, 32'd13);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst.level",        32'(level),        32'd0);
    check("arst.wr_ready",     32'(wr_ready),     32'd1);
    check("arst.sample_left",  sample_left,       32'd0);
    check("arst.sample_right", sample_right,      32'd0);
    check("arst.sample_valid", 32'(sample_valid), 32'd0);
    check("arst.underrun_cnt", 32'(underrun_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 500; n++) begin
        cycle($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < wp[ph],
              $urandom_range(0, 99) < rp[ph],
              $urandom, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
